mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single-port 6 KB RAM (Memory block: 1-cycle registered read, byte-masked write) between the RISC-V CPU (port 0) and a second bus master (port 1), e.g. a UART firmware loader or a DMA engine.
- Sits in SOC between the masters and the RAM; each master gets a request/acknowledge handshake.
- Provides round-robin or fixed-priority arbitration with a starvation guard.

Parameters:
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority to port 0, with starvation guard for port 1.
- STARVE_LIMIT, 4, ARB_MODE=1 only: after this many consecutive port-0 grants while port 1 is requesting, the next grant goes to port 1. Range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  port 0 request; held until m0_ack, inclusive
- m0_addr  in  32  port 0 byte address (bits [1:0] ignored)
- m0_wdata  in  32  port 0 write data, byte lanes pre-aligned
- m0_wmask  in  4  port 0 byte write mask; 0000 = read
- m0_rdata  out  32  port 0 read data, valid only while m0_ack=1
- m0_ack  out  1  one-cycle completion pulse for port 0
- m1_req, m1_addr, m1_wdata, m1_wmask, m1_rdata, m1_ack  same widths and meaning for port 1
- mem_addr  out  32  to RAM
- mem_rstrb  out  1  RAM read strobe
- mem_wdata  out  32  to RAM
- mem_wmask  out  4  to RAM
- mem_rdata  in  32  from RAM, valid the cycle after mem_rstrb

Behaviour:
- Reset values: state=IDLE, grant=0, last=1 (so port 0 wins the first round-robin tie), starve_cnt=0, m0_ack=m1_ack=0, mem_rstrb=0, mem_wmask=0000. mem_rstrb and mem_wmask are also gated by !reset, so no RAM write happens in any cycle where reset=1.
- State machine, 3 states:
  - IDLE: if neither req is asserted, stay. Otherwise latch winner into grant, update starve_cnt, go to ACCESS. Master inputs are sampled combinationally from the granted port while in ACCESS.
  - ACCESS: mem_addr/mem_wdata/mem_wmask come from the granted port. mem_rstrb=1 iff granted wmask==0000; mem_wmask=granted wmask. Go to RESP.
  - RESP: ack[grant]=1 for exactly this cycle. rdata[grant]=mem_rdata (reads) or mem_rdata, don't-care (writes). last<=grant. Go to IDLE.
- Latency: req sampled in IDLE at cycle N -> ack at cycle N+2. Maximum throughput is one transfer per 3 cycles.
- Non-granted port: ack=0, rdata=0. Both rdata outputs are 0 outside RESP.
- mem_addr outside ACCESS: held at the granted port's address, no strobes.
- Round-robin (ARB_MODE=0):
  - Both requesting -> grant = !last.
  - One requesting -> that one.
- Fixed priority (ARB_MODE=1):
  - Both requesting and starve_cnt < STARVE_LIMIT -> port 0, starve_cnt += 1.
  - Both requesting and starve_cnt == STARVE_LIMIT -> port 1, starve_cnt <= 0.
  - Any grant to port 1 clears starve_cnt.
  - Grant to port 0 with m1_req=0 clears starve_cnt.
  - starve_cnt is 4 bits and saturates at STARVE_LIMIT.
- Handshake rules:
  - A master must keep req and all its payload stable from assertion through its ack cycle.
  - In the cycle after ack, the master may present a new request or drop req.
  - req deasserted before ack is a protocol violation; the arbiter still completes the latched access.
- Simultaneous events:
  - Both ports asserting req in the same IDLE cycle resolve per ARB_MODE.
  - A request arriving in ACCESS or RESP waits for the next IDLE.
- Reset mid-operation: an in-flight access is abandoned, no ack is issued, and the next cycle is IDLE with reset values.

Decomposition:
- Package mem_arbiter_pkg:
  - State localparams ARB_IDLE=0, ARB_ACCESS=1, ARB_RESP=2 (2-bit state).
  - Mode constants ARB_RR=0, ARB_FIXED=1.
  - Starve counter width constant 4.
- One combinational sub-module mem_arb_pick:
  - Inputs: req[1:0], last, starve_cnt, mode.
  - Outputs: winner and next starve_cnt.
  - Lets the bench unit-test the arbitration policy in isolation.

Test Plan:
- Single read: preload RAM word 5 = 0xDEADBEEF. Port 0 requests addr 0x14, wmask 0000 -> mem_rstrb=1 one cycle later, m0_ack exactly 2 cycles after req, m0_rdata=0xDEADBEEF, m1_ack stays 0.
- Byte write then read: port 1 writes addr 0x21, wdata 0x0000AB00, wmask 0010, then reads 0x20 -> RAM word 8 bits [15:8]=0xAB, other bytes unchanged; m1_rdata shows the updated word.
- Round-robin contention (ARB_MODE=0): both ports hold req continuously for 6 transfers -> acks alternate 0,1,0,1,0,1, one transfer every 3 cycles.
- Starvation guard (ARB_MODE=1, STARVE_LIMIT=4): both hold req continuously -> grant pattern 0,0,0,0,1,0,0,0,0,1; starve_cnt returns to 0 after each port-1 grant.
- Reset mid-write: assert reset in the ACCESS cycle of a port-0 write with wmask 1111 -> RAM word unchanged, no ack, state IDLE, all outputs at reset values the next cycle.
- Back-to-back: port 0 issues a new read in the cycle after m0_ack while m1_req=0 -> second ack 3 cycles after the first, with no idle bubble beyond IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational arbitration policy: picks the winning port and the next starvation count.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic [1:0]          req_i,
  input  logic                last_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  input  logic                mode_i,
  output logic                winner_o,
  output logic [STARVE_W-1:0] starve_cnt_o
);

  localparam logic [STARVE_W-1:0] Limit = STARVE_W'(StarveLimit);

  always_comb begin
    winner_o     = 1'b0;
    starve_cnt_o = starve_cnt_i;
    if (mode_i == ARB_RR) begin
      starve_cnt_o = '0;
      winner_o     = (req_i == 2'b11) ? ~last_i : req_i[1];
    end else begin
      unique case (req_i)
        2'b11: begin
          // >= keeps the counter saturated even if it ever overshoots the limit
          if (starve_cnt_i >= Limit) begin
            winner_o     = 1'b1;
            starve_cnt_o = '0;
          end else begin
            winner_o     = 1'b0;
            starve_cnt_o = starve_cnt_i + 1'b1;
          end
        end
        2'b01: begin
          winner_o     = 1'b0;
          starve_cnt_o = '0;
        end
        2'b10: begin
          winner_o     = 1'b1;
          starve_cnt_o = '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port RAM: IDLE -> ACCESS -> RESP, one transfer per 3 cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE     = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam logic Mode = (ARB_MODE == 0) ? ARB_RR : ARB_FIXED;

  arb_state_e          state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic                winner;
  logic [STARVE_W-1:0] starve_nxt;
  logic [31:0]         g_addr, g_wdata;
  logic [3:0]          g_wmask;

  mem_arb_pick #(
    .StarveLimit(STARVE_LIMIT)
  ) u_pick (
    .req_i       ({m1_req, m0_req}),
    .last_i      (last_q),
    .starve_cnt_i(starve_q),
    .mode_i      (Mode),
    .winner_o    (winner),
    .starve_cnt_o(starve_nxt)
  );

  assign g_addr  = grant_q ? m1_addr  : m0_addr;
  assign g_wdata = grant_q ? m1_wdata : m0_wdata;
  assign g_wmask = grant_q ? m1_wmask : m0_wmask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    starve_d  = starve_q;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    mem_addr  = g_addr;
    mem_wdata = g_wdata;
    mem_rstrb = 1'b0;
    mem_wmask = 4'b0000;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0_req || m1_req) begin
          grant_d  = winner;
          starve_d = starve_nxt;
          state_d  = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        // Strobes are suppressed while reset is high so no RAM write can slip through.
        mem_rstrb = (g_wmask == 4'b0000) && !reset;
        mem_wmask = reset ? 4'b0000 : g_wmask;
        state_d   = ARB_RESP;
      end
      ARB_RESP: begin
        if (!reset) begin
          if (grant_q) begin
            m1_ack   = 1'b1;
            m1_rdata = mem_rdata;
          end else begin
            m0_ack   = 1'b1;
            m0_rdata = mem_rdata;
          end
        end
        last_d  = grant_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share one master stimulus stream.
module tb_mem_arbiter;

  localparam int Words = 1536;

  typedef struct packed {
    logic        port;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        preload;
  logic [1:0]  m_req;
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wmask [2];

  // Index 0: round-robin instance, index 1: fixed-priority instance.
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic        ack0 [2];
  logic        ack1 [2];
  logic [31:0] maddr [2];
  logic        mrstrb [2];
  logic [31:0] mwdata [2];
  logic [3:0]  mwmask [2];
  logic [31:0] mrdata [2];

  logic [31:0] ram [2][Words];
  logic [31:0] exp_mem [Words];
  exp_t        sb0[$];
  exp_t        sb1[$];
  int          n_vec = 0;
  int          n_err = 0;

  mem_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(m_req[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_wmask(m_wmask[0]),
    .m0_rdata(rd0[0]), .m0_ack(ack0[0]),
    .m1_req(m_req[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_wmask(m_wmask[1]),
    .m1_rdata(rd1[0]), .m1_ack(ack1[0]),
    .mem_addr(maddr[0]), .mem_rstrb(mrstrb[0]), .mem_wdata(mwdata[0]), .mem_wmask(mwmask[0]),
    .mem_rdata(mrdata[0])
  );

  mem_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(4)) u_fx (
    .clk(clk), .reset(reset),
    .m0_req(m_req[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_wmask(m_wmask[0]),
    .m0_rdata(rd0[1]), .m0_ack(ack0[1]),
    .m1_req(m_req[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_wmask(m_wmask[1]),
    .m1_rdata(rd1[1]), .m1_ack(ack1[1]),
    .mem_addr(maddr[1]), .mem_rstrb(mrstrb[1]), .mem_wdata(mwdata[1]), .mem_wmask(mwmask[1]),
    .mem_rdata(mrdata[1])
  );

  function automatic int widx(input logic [31:0] a);
    return int'(a[12:2]) % Words;
  endfunction

  function automatic logic [31:0] init_word(input int w);
    if (w == 5) return 32'hDEAD_BEEF;
    if (w == 8) return 32'h1122_3344;
    return 32'hA5A5_0000 | 32'(w);
  endfunction

  // RAM model: registered read on strobe, byte-masked write.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (preload) begin
        for (int w = 0; w < Words; w++) ram[i][w] <= init_word(w);
      end else begin
        if (mrstrb[i]) mrdata[i] <= ram[i][widx(maddr[i])];
        for (int b = 0; b < 4; b++)
          if (mwmask[i][b]) ram[i][widx(maddr[i])][8*b +: 8] <= mwdata[i][8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic mon(input int inst, input logic a0, input logic a1,
                     input logic [31:0] r0, input logic [31:0] r1);
    exp_t  e;
    string n = (inst == 0) ? "rr" : "fx";
    int    pend = (inst == 0) ? sb0.size() : sb1.size();
    if (a0 || a1) begin
      check_eq({n, "_dual_ack"}, 32'(a0 && a1), 32'd0);
      if (pend == 0) begin
        check_eq({n, "_ack_without_expect"}, 32'(a0 || a1), 32'd0);
      end else begin
        e = (inst == 0) ? sb0.pop_front() : sb1.pop_front();
        check_eq({n, "_ack_port"}, 32'(a1), 32'(e.port));
        if (e.rd) check_eq({n, "_rdata"}, a1 ? r1 : r0, e.data);
        check_eq({n, "_other_rdata"}, a1 ? r0 : r1, 32'd0);
      end
    end else begin
      check_eq({n, "_rdata_idle"}, r0 | r1, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, ack0[0], ack1[0], rd0[0], rd1[0]);
      mon(1, ack0[1], ack1[1], rd0[1], rd1[1]);
    end
  end

  task automatic model(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, output exp_t e);
    int w = widx(addr);
    e.port = port;
    e.rd   = (wmask == 4'b0000);
    e.data = '0;
    if (e.rd) e.data = exp_mem[w];
    else for (int b = 0; b < 4; b++) if (wmask[b]) exp_mem[w][8*b +: 8] = wdata[8*b +: 8];
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 after the ack with req dropped.
  task automatic xfer(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wmask, output time t_ack);
    exp_t e;
    int   k = 0;
    logic done = 1'b0;
    model(port, addr, wdata, wmask, e);
    sb0.push_back(e);
    sb1.push_back(e);
    m_req[port] = 1'b1; m_addr[port] = addr; m_wdata[port] = wdata; m_wmask[port] = wmask;
    while (!done && k < 8) begin
      @(negedge clk);
      if (k == 1) begin
        for (int i = 0; i < 2; i++) begin
          check_eq("access_rstrb", 32'(mrstrb[i]), 32'(wmask == 4'b0000));
          check_eq("access_wmask", 32'(mwmask[i]), 32'(wmask));
          check_eq("access_addr", maddr[i], addr);
        end
      end
      if (ack0[0] || ack1[0]) done = 1'b1;
      else k++;
    end
    check_eq("ack_latency", 32'(k), 32'd2);
    check_eq("fx_ack_sync", 32'(ack0[1] || ack1[1]), 32'(done));
    t_ack = $time;
    @(posedge clk); #1;
    m_req[port] = 1'b0; m_wmask[port] = 4'b0000;
  endtask

  task automatic contention();
    exp_t e;
    int   k;
    logic got;
    m_req = 2'b11;
    m_addr[0] = 32'h14; m_wmask[0] = 4'b0000;
    m_addr[1] = 32'h20; m_wmask[1] = 4'b0000;
    for (int t = 0; t < 10; t++) begin
      model(1'(t % 2), (t % 2 == 1) ? 32'h20 : 32'h14, 32'd0, 4'b0000, e);
      sb0.push_back(e);
      model(1'(t % 5 == 4), (t % 5 == 4) ? 32'h20 : 32'h14, 32'd0, 4'b0000, e);
      sb1.push_back(e);
    end
    for (int t = 0; t < 10; t++) begin
      k = 0;
      got = 1'b0;
      while (!got && k < 8) begin
        @(negedge clk);
        if (ack0[0] || ack1[0]) got = 1'b1;
        else k++;
      end
      check_eq("cont_spacing", 32'(k), 32'd2);
      check_eq("cont_fx_sync", 32'(ack0[1] || ack1[1]), 32'(got));
    end
    @(posedge clk); #1;
    m_req = 2'b00;
  endtask

  task automatic reset_mid_write();
    m_req[0] = 1'b1; m_addr[0] = 32'h30; m_wdata[0] = 32'hCAFE_F00D; m_wmask[0] = 4'b1111;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_eq("rst_gate_wmask", 32'(mwmask[i]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; m_req[0] = 1'b0; m_wmask[0] = 4'b0000;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("post_rst_ack", 32'(ack0[i] || ack1[i]), 32'd0);
      check_eq("post_rst_rstrb", 32'(mrstrb[i]), 32'd0);
      check_eq("post_rst_wmask", 32'(mwmask[i]), 32'd0);
      check_eq("post_rst_ram", ram[i][12], init_word(12));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    time t1, t2;
    reset = 1'b1; preload = 1'b1; m_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_wmask[i] = '0;
    end
    for (int w = 0; w < Words; w++) exp_mem[w] = init_word(w);
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("reset_ack", 32'({ack1[i], ack0[i]}), 32'd0);
      check_eq("reset_rstrb", 32'(mrstrb[i]), 32'd0);
      check_eq("reset_wmask", 32'(mwmask[i]), 32'd0);
      check_eq("reset_rdata", rd0[i] | rd1[i], 32'd0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    xfer(1'b0, 32'h14, 32'd0, 4'b0000, t1);
    xfer(1'b1, 32'h21, 32'h0000_AB00, 4'b0010, t1);
    xfer(1'b1, 32'h20, 32'd0, 4'b0000, t1);
    for (int i = 0; i < 2; i++) check_eq("byte_write_word8", ram[i][8], 32'h1122_AB44);

    contention();
    reset_mid_write();
    xfer(1'b0, 32'h30, 32'd0, 4'b0000, t1);

    xfer(1'b0, 32'h14, 32'd0, 4'b0000, t1);
    xfer(1'b0, 32'h24, 32'd0, 4'b0000, t2);
    check_eq("b2b_gap_cycles", 32'((t2 - t1) / 10), 32'd3);

    repeat (3) @(negedge clk);
    check_eq("rr_pending", 32'(sb0.size()), 32'd0);
    check_eq("fx_pending", 32'(sb1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
